// File: rtl/vip_pkg.sv
// Shared encodings for the VIP pattern source: pattern modes, FSM states, bar count.
package vip_pkg;

  localparam int NUM_BARS = 8;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/vip_pattern_pixel.sv
// Pure combinational pixel generator: scan position, frame index, bar index and mode in,
// one packed pixel out (channel 0 in the MSBs).
module vip_pattern_pixel
  import vip_pkg::*;
#(
  parameter int CWIDTH   = 8,
  parameter int CHANNELS = 3,
  parameter int DWIDTH   = 24,
  parameter int DIM_W    = 11
) (
  input  logic [DIM_W-1:0]  x,
  input  logic              y_tile,
  input  logic [DIM_W-1:0]  frame,
  input  logic [2:0]        bar,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] color,
  output logic [DWIDTH-1:0] pixel
);

  logic [DIM_W-1:0] ramp_sum;
  logic [2:0]       bar_code;
  logic             checker_on;

  assign ramp_sum   = x + frame;
  assign bar_code   = 3'(NUM_BARS - 1) - bar;
  assign checker_on = x[3] ^ y_tile ^ frame[0];

  // Bar code bits map onto channels modulo 3, so bar 0 is white and bar 7 is black.
  always_comb begin
    pixel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode)
        MODE_SOLID: pixel[(CHANNELS-1-c)*CWIDTH +: CWIDTH] = color[(CHANNELS-1-c)*CWIDTH +: CWIDTH];
        MODE_RAMP:  pixel[(CHANNELS-1-c)*CWIDTH +: CWIDTH] = CWIDTH'(ramp_sum);
        MODE_BARS:  pixel[(CHANNELS-1-c)*CWIDTH +: CWIDTH] = {CWIDTH{bar_code[2'((CHANNELS-1-c) % 3)]}};
        default:    pixel[(CHANNELS-1-c)*CWIDTH +: CWIDTH] = {CWIDTH{checker_on}};
      endcase
    end
  end

endmodule

// File: rtl/vip_pattern_source.sv
// Frame source: latches a run descriptor on start, then raster-scans N frames of WxH pixels
// into a FIFO write port, with one idle cycle between frames.
module vip_pattern_source
  import vip_pkg::*;
#(
  parameter int CWIDTH   = 8,
  parameter int CHANNELS = 3,
  parameter int DWIDTH   = 24,
  parameter int DIM_W    = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_num_frame,
  input  logic [DWIDTH-1:0] cfg_color,
  output logic [DIM_W-1:0]  width,
  output logic [DIM_W-1:0]  height,
  output logic [DIM_W-1:0]  num_frame,
  output logic              media_type,
  input  logic              fifo_full,
  output logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_wrreq,
  output logic              sof,
  output logic              frame_done,
  output logic              busy
);

  if (DWIDTH != CHANNELS * CWIDTH) begin : g_bad_width
    $error("DWIDTH must equal CHANNELS*CWIDTH");
  end

  state_e            state;
  logic [DIM_W-1:0]  x, y, frame;
  logic [DIM_W-1:0]  bar_cnt, bar_w;
  logic [2:0]        bar;
  logic [1:0]        run_mode;
  logic [DWIDTH-1:0] run_color;
  logic [DIM_W-1:0]  bar_w_init;
  logic              cfg_ok, last_x, last_y, last_frame, last_bar_px;

  assign cfg_ok      = (|cfg_width) & (|cfg_height) & (|cfg_num_frame);
  assign bar_w_init  = ((cfg_width >> 3) == '0) ? DIM_W'(1) : (cfg_width >> 3);
  assign last_x      = (x == width - DIM_W'(1));
  assign last_y      = (y == height - DIM_W'(1));
  assign last_frame  = (frame == num_frame - DIM_W'(1));
  assign last_bar_px = (bar_cnt == bar_w - DIM_W'(1));

  assign fifo_wrreq = (state == ST_RUN) & ~fifo_full;
  assign sof        = (state == ST_RUN) && (x == '0) && (y == '0);

  vip_pattern_pixel #(
    .CWIDTH  (CWIDTH),
    .CHANNELS(CHANNELS),
    .DWIDTH  (DWIDTH),
    .DIM_W   (DIM_W)
  ) u_pixel (
    .x     (x),
    .y_tile(y[3]),
    .frame (frame),
    .bar   (bar),
    .mode  (run_mode),
    .color (run_color),
    .pixel (fifo_data)
  );

  // Scan counters advance only on an actual write, so a full FIFO freezes the pixel in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      frame      <= '0;
      bar        <= '0;
      bar_cnt    <= '0;
      bar_w      <= '0;
      run_mode   <= '0;
      run_color  <= '0;
      width      <= '0;
      height     <= '0;
      num_frame  <= '0;
      media_type <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (start && cfg_ok) begin
            width      <= cfg_width;
            height     <= cfg_height;
            num_frame  <= cfg_num_frame;
            media_type <= (cfg_num_frame > DIM_W'(1));
            run_mode   <= cfg_mode;
            run_color  <= cfg_color;
            bar_w      <= bar_w_init;
            x          <= '0;
            y          <= '0;
            frame      <= '0;
            bar        <= '0;
            bar_cnt    <= '0;
            busy       <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fifo_wrreq) begin
            if (last_x) begin
              x       <= '0;
              bar     <= '0;
              bar_cnt <= '0;
              if (last_y) begin
                y          <= '0;
                frame_done <= 1'b1;
                state      <= ST_GAP;
              end else begin
                y <= y + DIM_W'(1);
              end
            end else begin
              x <= x + DIM_W'(1);
              if (last_bar_px) begin
                bar_cnt <= '0;
                if (bar != 3'(NUM_BARS - 1)) bar <= bar + 3'd1;
              end else begin
                bar_cnt <= bar_cnt + DIM_W'(1);
              end
            end
          end
        end
        ST_GAP: begin
          frame_done <= 1'b0;
          if (last_frame) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            frame <= frame + DIM_W'(1);
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vip_pattern_source.sv
// Self-checking bench for vip_pattern_source: a scoreboard of expected pixels is filled when a run
// is started and drained by a monitor on every FIFO write.
module tb_vip_pattern_source;
  import vip_pkg::*;

  localparam int CWIDTH   = 8;
  localparam int CHANNELS = 3;
  localparam int DWIDTH   = 24;
  localparam int DIM_W    = 11;

  logic              clock, reset, start, fifo_full;
  logic [1:0]        cfg_mode;
  logic [DIM_W-1:0]  cfg_width, cfg_height, cfg_num_frame;
  logic [DWIDTH-1:0] cfg_color;
  logic [DIM_W-1:0]  width, height, num_frame;
  logic              media_type, fifo_wrreq, sof, frame_done, busy;
  logic [DWIDTH-1:0] fifo_data;

  typedef struct {
    logic [DWIDTH-1:0] data;
    logic              sof;
  } exp_t;

  exp_t              sb[$];
  logic [DWIDTH-1:0] captured[$];
  int                vectors = 0;
  int                miscompares = 0;
  int                write_count = 0;
  bit                rand_full = 0;

  vip_pattern_source #(
    .CWIDTH(CWIDTH), .CHANNELS(CHANNELS), .DWIDTH(DWIDTH), .DIM_W(DIM_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_num_frame(cfg_num_frame),
    .cfg_color(cfg_color), .width(width), .height(height), .num_frame(num_frame),
    .media_type(media_type), .fifo_full(fifo_full), .fifo_data(fifo_data),
    .fifo_wrreq(fifo_wrreq), .sof(sof), .frame_done(frame_done), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Random back-pressure, changed just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (rand_full) fifo_full = 1'($urandom_range(0, 1));
  end

  // Scoreboard drain: every write cycle pops one expected pixel.
  always @(negedge clock) begin
    exp_t e;
    if (fifo_full === 1'b1) begin
      vectors++;
      if (fifo_wrreq !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wrreq_while_full got %b expected 0", fifo_wrreq);
      end
    end
    if (fifo_wrreq === 1'b1) begin
      write_count++;
      captured.push_back(fifo_data);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write got %h expected no write", fifo_data);
      end else begin
        e = sb.pop_front();
        if (fifo_data !== e.data) begin
          miscompares++;
          $display("[TB] FAIL pixel_data got %h expected %h", fifo_data, e.data);
        end
        vectors++;
        if (sof !== e.sof) begin
          miscompares++;
          $display("[TB] FAIL sof got %b expected %b", sof, e.sof);
        end
      end
    end
  end

  function automatic logic [DWIDTH-1:0] model_pixel(input int mode, input int x, input int y,
                                                    input int f, input int w,
                                                    input logic [DWIDTH-1:0] color);
    int         bw, b;
    logic [7:0] v;
    logic [2:0] code;
    case (mode)
      0: return color;
      1: begin
        v = 8'((x + f) % 256);
        return {v, v, v};
      end
      2: begin
        bw = w / 8;
        if (bw < 1) bw = 1;
        b = x / bw;
        if (b > 7) b = 7;
        code = 3'(7 - b);
        return {{8{code[2]}}, {8{code[1]}}, {8{code[0]}}};
      end
      default: return (((x / 8) + (y / 8) + f) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push_run(input int w, input int h, input int n, input int mode,
                          input logic [DWIDTH-1:0] color);
    exp_t e;
    for (int f = 0; f < n; f++)
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++) begin
          e.data = model_pixel(mode, xx, yy, f, w, color);
          e.sof  = (xx == 0 && yy == 0);
          sb.push_back(e);
        end
  endtask

  task automatic applyStimulus(input int w, input int h, input int n, input int mode,
                               input logic [DWIDTH-1:0] color);
    @(posedge clock); #1;
    cfg_width     = DIM_W'(w);
    cfg_height    = DIM_W'(h);
    cfg_num_frame = DIM_W'(n);
    cfg_mode      = 2'(mode);
    cfg_color     = color;
    start         = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_run(input int budget, output int busy_cycles, output int fd_count,
                          output int fd_wr, output bit timed_out);
    busy_cycles = 0;
    fd_count    = 0;
    fd_wr       = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
      if (frame_done) begin
        fd_count++;
        if (fifo_wrreq) fd_wr++;
      end
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({busy, fifo_wrreq, frame_done, sof, media_type} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b expected 00000",
               {busy, fifo_wrreq, frame_done, sof, media_type});
    end
    vectors++;
    if ({width, height, num_frame} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_descriptor got %0d/%0d/%0d expected 0/0/0", width, height, num_frame);
    end
    vectors++;
    if (fifo_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got %h expected 000000", fifo_data);
    end
  endtask

  task automatic test_ramp();
    int bc, fd, fdw, w0;
    bit to;
    w0 = write_count;
    push_run(4, 2, 1, int'(MODE_RAMP), 24'h0);
    applyStimulus(4, 2, 1, int'(MODE_RAMP), 24'h0);
    vectors++;
    if (busy !== 1'b1 || width !== 11'd4 || height !== 11'd2 || num_frame !== 11'd1 || media_type !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ramp_descriptor got busy=%b %0dx%0dx%0d mt=%b expected 1 4x2x1 0",
               busy, width, height, num_frame, media_type);
    end
    wait_run(200, bc, fd, fdw, to);
    vectors++;
    if (to || bc != 9 || fd != 1 || fdw != 0) begin
      miscompares++;
      $display("[TB] FAIL ramp_timing got to=%b busy=%0d fd=%0d fdw=%0d expected 0 9 1 0", to, bc, fd, fdw);
    end
    vectors++;
    if (write_count - w0 != 8 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ramp_writes got %0d left=%0d expected 8 left=0", write_count - w0, sb.size());
    end
  endtask

  task automatic test_bars();
    int bc, fd, fdw;
    bit to;
    captured.delete();
    push_run(16, 1, 1, int'(MODE_BARS), 24'h0);
    applyStimulus(16, 1, 1, int'(MODE_BARS), 24'h0);
    wait_run(200, bc, fd, fdw, to);
    vectors++;
    if (to || captured.size() != 16) begin
      miscompares++;
      $display("[TB] FAIL bars_count got %0d expected 16", captured.size());
    end else begin
      vectors++;
      if (captured[0] !== 24'hFFFFFF || captured[1] !== 24'hFFFFFF) begin
        miscompares++;
        $display("[TB] FAIL bars_white got %h %h expected ffffff ffffff", captured[0], captured[1]);
      end
      vectors++;
      if (captured[2] !== 24'hFFFF00) begin
        miscompares++;
        $display("[TB] FAIL bars_second got %h expected ffff00", captured[2]);
      end
      vectors++;
      if (captured[14] !== 24'h000000 || captured[15] !== 24'h000000) begin
        miscompares++;
        $display("[TB] FAIL bars_black got %h %h expected 000000 000000", captured[14], captured[15]);
      end
    end
  endtask

  task automatic test_stall();
    int bc, fd, fdw, w0;
    bit to;
    w0 = write_count;
    push_run(4, 2, 1, int'(MODE_RAMP), 24'h0);
    rand_full = 1'b1;
    applyStimulus(4, 2, 1, int'(MODE_RAMP), 24'h0);
    wait_run(500, bc, fd, fdw, to);
    rand_full = 1'b0;
    @(posedge clock); #2 fifo_full = 1'b0;
    vectors++;
    if (to || fd != 1 || bc < 9) begin
      miscompares++;
      $display("[TB] FAIL stall_timing got to=%b fd=%0d busy=%0d expected 0 1 >=9", to, fd, bc);
    end
    vectors++;
    if (write_count - w0 != 8 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_writes got %0d left=%0d expected 8 left=0", write_count - w0, sb.size());
    end
  endtask

  task automatic test_multi_frame();
    int bc, fd, fdw, w0;
    bit to;
    w0 = write_count;
    captured.delete();
    push_run(2, 2, 3, int'(MODE_CHECKER), 24'h0);
    applyStimulus(2, 2, 3, int'(MODE_CHECKER), 24'h0);
    vectors++;
    if (media_type !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL multi_media_type got %b expected 1", media_type);
    end
    wait_run(200, bc, fd, fdw, to);
    vectors++;
    if (to || bc != 15 || fd != 3 || fdw != 0) begin
      miscompares++;
      $display("[TB] FAIL multi_timing got to=%b busy=%0d fd=%0d fdw=%0d expected 0 15 3 0", to, bc, fd, fdw);
    end
    vectors++;
    if (write_count - w0 != 12 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL multi_writes got %0d left=%0d expected 12 left=0", write_count - w0, sb.size());
    end else begin
      vectors++;
      if (captured[0] !== 24'h000000 || captured[4] !== 24'hFFFFFF || captured[8] !== 24'h000000) begin
        miscompares++;
        $display("[TB] FAIL multi_invert got %h %h %h expected 000000 ffffff 000000",
                 captured[0], captured[4], captured[8]);
      end
    end
  endtask

  task automatic test_invalid_and_restart();
    int bc, fd, fdw, w0, seen;
    bit to;
    w0   = write_count;
    seen = 0;
    applyStimulus(4, 0, 1, int'(MODE_RAMP), 24'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (busy) seen++;
    end
    vectors++;
    if (seen != 0 || write_count != w0) begin
      miscompares++;
      $display("[TB] FAIL invalid_cfg got busy_cycles=%0d writes=%0d expected 0 0", seen, write_count - w0);
    end
    push_run(4, 2, 1, int'(MODE_RAMP), 24'h0);
    applyStimulus(4, 2, 1, int'(MODE_RAMP), 24'h0);
    repeat (2) @(posedge clock);
    #1;
    cfg_width     = 11'd2;
    cfg_height    = 11'd2;
    cfg_num_frame = 11'd2;
    cfg_mode      = 2'(MODE_SOLID);
    cfg_color     = 24'h123456;
    start         = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_run(200, bc, fd, fdw, to);
    vectors++;
    if (to || width !== 11'd4 || num_frame !== 11'd1 || media_type !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_start_desc got to=%b w=%0d n=%0d mt=%b expected 0 4 1 0",
               to, width, num_frame, media_type);
    end
    vectors++;
    if (write_count - w0 != 8 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL busy_start_writes got %0d left=%0d expected 8 left=0", write_count - w0, sb.size());
    end
  endtask

  task automatic test_reset_midrun();
    int bc, fd, fdw, w0;
    bit to, hit;
    w0  = write_count;
    hit = 1'b0;
    push_run(8, 8, 1, int'(MODE_RAMP), 24'h0);
    applyStimulus(8, 8, 1, int'(MODE_RAMP), 24'h0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (write_count - w0 >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (!hit || fifo_wrreq !== 1'b0 || busy !== 1'b0 || width !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset got hit=%b wrreq=%b busy=%b width=%0d expected 1 0 0 0",
               hit, fifo_wrreq, busy, width);
    end
    vectors++;
    if (write_count - w0 != 5) begin
      miscompares++;
      $display("[TB] FAIL midrun_partial got %0d expected 5", write_count - w0);
    end
    @(posedge clock); #1 reset = 1'b0;
    sb.delete();
    captured.delete();
    w0 = write_count;
    push_run(8, 8, 1, int'(MODE_RAMP), 24'h0);
    applyStimulus(8, 8, 1, int'(MODE_RAMP), 24'h0);
    wait_run(400, bc, fd, fdw, to);
    vectors++;
    if (to || bc != 65 || write_count - w0 != 64 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL restart_run got to=%b busy=%0d writes=%0d left=%0d expected 0 65 64 0",
               to, bc, write_count - w0, sb.size());
    end else begin
      vectors++;
      if (captured[0] !== 24'h000000 || captured[9] !== 24'h010101) begin
        miscompares++;
        $display("[TB] FAIL restart_data got %h %h expected 000000 010101", captured[0], captured[9]);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    fifo_full     = 1'b0;
    cfg_mode      = '0;
    cfg_width     = '0;
    cfg_height    = '0;
    cfg_num_frame = '0;
    cfg_color     = '0;
    test_reset();
    test_ramp();
    test_bars();
    test_stall();
    test_multi_frame();
    test_invalid_and_restart();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
